// File: rtl/kb_tx_sequencer.sv
// rtl/kb_tx_sequencer.sv - pops PS/2 scan codes, drops break/extended codes, feeds translator, writes UART TX FIFO.
// Optional KB_CRLF_EN: append LF (8'h0A) after every CR (8'h0D) character.
module kb_tx_sequencer #(
  parameter logic [7:0] BREAK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE   = 8'hE0,
  parameter int         DROP_CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_kb_buf_empty,
  input  logic [7:0]            i_key_code,
  output logic                  o_rd_key_code,
  output logic [7:0]            o_xlat_code,
  input  logic [7:0]            i_ascii_code,
  input  logic                  i_tx_full,
  output logic                  o_wr_uart,
  output logic [7:0]            o_wr_data,
  output logic                  o_busy,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

`ifdef KB_CRLF_EN
  typedef enum logic [1:0] {IDLE, XLAT, SEND, SEND_LF} state_t;
`else
  typedef enum logic [1:0] {IDLE, XLAT, SEND} state_t;
`endif

  state_t                state, state_n;
  logic                  skip_next, skip_next_n;
  logic [7:0]            xlat_n;
  logic [7:0]            char_q, char_n;
  logic                  drop_inc;
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      skip_next   <= 1'b0;
      o_xlat_code <= 8'h00;
      char_q      <= 8'h00;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      skip_next   <= skip_next_n;
      o_xlat_code <= xlat_n;
      char_q      <= char_n;
      if (drop_inc && (drop_cnt != '1))
        drop_cnt <= drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_n       = state;
    skip_next_n   = skip_next;
    xlat_n        = o_xlat_code;
    char_n        = char_q;
    drop_inc      = 1'b0;
    o_rd_key_code = 1'b0;
    o_wr_uart     = 1'b0;
    o_wr_data     = 8'h00;
    case (state)
      IDLE: begin
        if (!i_kb_buf_empty) begin
          o_rd_key_code = 1'b1;
          if (i_key_code == BREAK_CODE) begin
            skip_next_n = 1'b1;
            drop_inc    = 1'b1;
          end else if (i_key_code == EXT_CODE) begin
            drop_inc = 1'b1;
          end else if (skip_next) begin
            skip_next_n = 1'b0;
            drop_inc    = 1'b1;
          end else begin
            xlat_n  = i_key_code;
            state_n = XLAT;
          end
        end
      end
      XLAT: begin
        char_n = i_ascii_code;
        if (i_ascii_code == 8'h00) begin
          drop_inc = 1'b1;
          state_n  = IDLE;
        end else begin
          state_n = SEND;
        end
      end
      SEND: begin
        if (!i_tx_full) begin
          o_wr_uart = 1'b1;
          o_wr_data = char_q;
`ifdef KB_CRLF_EN
          state_n   = (char_q == 8'h0D) ? SEND_LF : IDLE;
`else
          state_n   = IDLE;
`endif
        end
      end
`ifdef KB_CRLF_EN
      SEND_LF: begin
        if (!i_tx_full) begin
          o_wr_uart = 1'b1;
          o_wr_data = 8'h0A;
          state_n   = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    // Strobes are suppressed during reset so no code is lost and no pending character escapes.
    if (i_reset) begin
      o_rd_key_code = 1'b0;
      o_wr_uart     = 1'b0;
      o_wr_data     = 8'h00;
    end
  end

  assign o_busy     = (state != IDLE);
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_kb_tx_sequencer.sv
// tb/tb_kb_tx_sequencer.sv - scoreboard bench for kb_tx_sequencer with queue-backed key buffer and translator model.
module tb_kb_tx_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_kb_buf_empty;
  logic [7:0] i_key_code;
  logic       o_rd_key_code;
  logic [7:0] o_xlat_code;
  logic [7:0] i_ascii_code;
  logic       i_tx_full;
  logic       o_wr_uart;
  logic [7:0] o_wr_data;
  logic       o_busy;
  logic [7:0] o_drop_cnt;

  kb_tx_sequencer dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_kb_buf_empty (i_kb_buf_empty),
    .i_key_code     (i_key_code),
    .o_rd_key_code  (o_rd_key_code),
    .o_xlat_code    (o_xlat_code),
    .i_ascii_code   (i_ascii_code),
    .i_tx_full      (i_tx_full),
    .o_wr_uart      (o_wr_uart),
    .o_wr_data      (o_wr_data),
    .o_busy         (o_busy),
    .o_drop_cnt     (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    case (o_xlat_code)
      8'h1C:   i_ascii_code = 8'h61;
      8'h5A:   i_ascii_code = 8'h0D;
      default: i_ascii_code = 8'h00;
    endcase
  end

  logic [7:0] kq[$];
  logic [7:0] exp_q[$];
  int  n_chk = 0, n_pass = 0;
  int  cyc = 0, n_pops = 0, n_writes = 0, pop_cyc = 0, wr_cyc = 0;
  bit  pop_pending = 1'b0;
  bit  m_skip = 1'b0;
  int  m_drop = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  function automatic void drive_buf();
    i_kb_buf_empty = (kq.size() == 0);
    i_key_code     = (kq.size() == 0) ? 8'h00 : kq[0];
  endfunction

  function automatic void model_drop();
    if (m_drop < 255) m_drop++;
  endfunction

  // Reference: each code's fate is decided by the keyboard protocol rules in arrival order.
  task automatic push_code(input logic [7:0] c);
    kq.push_back(c);
    drive_buf();
    if (c == 8'hF0) begin
      m_skip = 1'b1;
      model_drop();
    end else if (c == 8'hE0) begin
      model_drop();
    end else if (m_skip) begin
      m_skip = 1'b0;
      model_drop();
    end else if (c == 8'h1C) begin
      exp_q.push_back(8'h61);
    end else if (c == 8'h5A) begin
      exp_q.push_back(8'h0D);
`ifdef KB_CRLF_EN
      exp_q.push_back(8'h0A);
`endif
    end else begin
      model_drop();
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((kq.size() != 0 || o_busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(n < budget, "wait_quiet_timeout", n, budget);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    exp_q.delete();
    step();
    i_reset = 1'b0;
    kq.delete();
    drive_buf();
    m_skip = 1'b0;
    m_drop = 0;
  endtask

  // Monitor: samples at the falling edge, pops the scoreboard on every write.
  always @(negedge i_clk) begin
    logic [7:0] e;
    cyc++;
    pop_pending = o_rd_key_code;
    if (o_rd_key_code) begin
      n_pops++;
      pop_cyc = cyc;
    end
    if (o_wr_uart) begin
      n_writes++;
      wr_cyc = cyc;
      chk(!i_tx_full, "write_into_full", int'(i_tx_full), 0);
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", int'(o_wr_data), 0);
      end else begin
        e = exp_q.pop_front();
        chk(o_wr_data == e, "wr_data", int'(o_wr_data), int'(e));
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (pop_pending) begin
      if (kq.size() > 0) void'(kq.pop_front());
      pop_pending = 1'b0;
      drive_buf();
    end
  end

  initial begin
    int p0, w0;
    logic [7:0] codes [6];
    codes[0] = 8'h1C; codes[1] = 8'h5A; codes[2] = 8'hF0;
    codes[3] = 8'hE0; codes[4] = 8'h77; codes[5] = 8'h1C;

    i_reset   = 1'b1;
    i_tx_full = 1'b0;
    drive_buf();
    step();
    step();
    chk(o_busy == 1'b0, "reset_busy", int'(o_busy), 0);
    chk(o_wr_uart == 1'b0, "reset_wr_uart", int'(o_wr_uart), 0);
    chk(o_wr_data == 8'h00, "reset_wr_data", int'(o_wr_data), 0);
    chk(o_xlat_code == 8'h00, "reset_xlat_code", int'(o_xlat_code), 0);
    chk(o_drop_cnt == 8'h00, "reset_drop_cnt", int'(o_drop_cnt), 0);
    chk(o_rd_key_code == 1'b0, "reset_rd", int'(o_rd_key_code), 0);
    i_reset = 1'b0;

    // Make/break
    p0 = n_pops; w0 = n_writes;
    push_code(8'h1C); push_code(8'hF0); push_code(8'h1C);
    wait_quiet(100);
    chk(n_pops - p0 == 3, "mb_pops", n_pops - p0, 3);
    chk(n_writes - w0 == 1, "mb_writes", n_writes - w0, 1);
    chk(o_drop_cnt == 8'd2, "mb_drop_cnt", int'(o_drop_cnt), 2);
    w0 = n_writes;
    push_code(8'h1C);
    wait_quiet(100);
    chk(n_writes - w0 == 1, "skip_cleared_write", n_writes - w0, 1);

    // Extended prefix
    do_reset();
    w0 = n_writes;
    push_code(8'hE0); push_code(8'h1C); push_code(8'hE0); push_code(8'hF0); push_code(8'h1C);
    wait_quiet(100);
    chk(n_writes - w0 == 1, "ext_writes", n_writes - w0, 1);
    chk(o_drop_cnt == 8'd4, "ext_drop_cnt", int'(o_drop_cnt), 4);

    // Best-case latency pop->write
    push_code(8'h1C);
    wait_quiet(100);
    chk(wr_cyc - pop_cyc == 2, "latency", wr_cyc - pop_cyc, 2);

    // Backpressure
    i_tx_full = 1'b1;
    push_code(8'h1C);
    repeat (3) step();
    push_code(8'h1C); push_code(8'h5A);
    p0 = n_pops; w0 = n_writes;
    repeat (20) step();
    chk(n_pops - p0 == 0, "bp_no_pops", n_pops - p0, 0);
    chk(n_writes - w0 == 0, "bp_no_writes", n_writes - w0, 0);
    chk(o_busy == 1'b1, "bp_busy", int'(o_busy), 1);
    i_tx_full = 1'b0;
    @(negedge i_clk);
    #1;
    chk(o_wr_uart == 1'b1, "bp_release_write", int'(o_wr_uart), 1);
    chk(o_wr_data == 8'h61, "bp_release_data", int'(o_wr_data), 8'h61);
    wait_quiet(100);
    chk(n_pops - p0 == 2, "bp_pops_resume", n_pops - p0, 2);

    // Enter
    w0 = n_writes;
    push_code(8'h5A);
    wait_quiet(100);
`ifdef KB_CRLF_EN
    chk(n_writes - w0 == 2, "enter_writes", n_writes - w0, 2);
`else
    chk(n_writes - w0 == 1, "enter_writes", n_writes - w0, 1);
`endif

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) i_tx_full = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) == 0) push_code(codes[$urandom_range(0, 5)]);
      if ($urandom_range(0, 9) == 0) push_code(8'($urandom));
      step();
    end
    i_tx_full = 1'b0;
    wait_quiet(3000);
    chk(int'(o_drop_cnt) == m_drop, "rand_drop_cnt", int'(o_drop_cnt), m_drop);

    // Saturation
    do_reset();
    w0 = n_writes;
    for (int i = 0; i < 300; i++) push_code(8'h77);
    wait_quiet(3000);
    chk(o_drop_cnt == 8'hFF, "sat_drop_cnt", int'(o_drop_cnt), 8'hFF);
    chk(n_writes - w0 == 0, "sat_no_writes", n_writes - w0, 0);

    // Reset during a stalled SEND
    i_tx_full = 1'b1;
    push_code(8'h1C);
    repeat (3) step();
    chk(o_busy == 1'b1, "rst_in_send", int'(o_busy), 1);
    w0 = n_writes;
    i_reset = 1'b1;
    exp_q.delete();
    @(negedge i_clk);
    #1;
    chk(o_wr_uart == 1'b0, "rst_cycle_no_write", int'(o_wr_uart), 0);
    @(posedge i_clk);
    #2;
    chk(o_busy == 1'b0, "rst_busy", int'(o_busy), 0);
    chk(o_wr_uart == 1'b0, "rst_wr_uart", int'(o_wr_uart), 0);
    chk(o_wr_data == 8'h00, "rst_wr_data", int'(o_wr_data), 0);
    chk(o_xlat_code == 8'h00, "rst_xlat_code", int'(o_xlat_code), 0);
    chk(o_drop_cnt == 8'h00, "rst_drop_cnt", int'(o_drop_cnt), 0);
    i_reset = 1'b0;
    m_skip = 1'b0;
    m_drop = 0;
    i_tx_full = 1'b0;
    repeat (5) step();
    chk(n_writes - w0 == 0, "rst_aborted_char", n_writes - w0, 0);

    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/kb_tx_sequencer.md
# kb_tx_sequencer

Controller that sits between the PS/2 key-code buffer and the UART transmitter. It pops scan codes from the keyboard buffer and discards PS/2 break sequences (F0 xx) and extended prefixes (E0). It drives the remaining make codes into the external key-to-ASCII translator and writes the resulting characters into the UART TX FIFO, throttled by the FIFO full flag. It replaces the direct "read whenever not empty / write whenever not empty" wiring, so no key is lost when the TX FIFO backs up.

## Interface
Parameters:
- BREAK_CODE, 8'hF0, scan code that marks a key release; the code following it is discarded
- EXT_CODE, 8'hE0, extended-key prefix; discarded, does not affect the following code
- DROP_CNT_W, 8, width of the dropped-code counter

Ports:
- i_clk  input  1  system clock (100 MHz)
- i_reset  input  1  synchronous, active-high reset
- i_kb_buf_empty  input  1  key-code buffer empty flag
- i_key_code  input  8  head of key-code buffer (show-ahead; valid while not empty)
- o_rd_key_code  output  1  one-cycle pop strobe to key-code buffer
- o_xlat_code  output  8  registered scan code driven to the translator
- i_ascii_code  input  8  translator result (combinational from o_xlat_code); 8'h00 = unmapped
- i_tx_full  input  1  UART TX FIFO full flag
- o_wr_uart  output  1  one-cycle write strobe to UART TX FIFO
- o_wr_data  output  8  character written with o_wr_uart
- o_busy  output  1  high in every state except IDLE
- o_drop_cnt  output  DROP_CNT_W  count of codes consumed without producing a character (saturating)

## Operation
- FSM states: IDLE, XLAT, SEND, SEND_LF (SEND_LF only with macro), plus a 1-bit skip_next flag.
- IDLE: if !i_kb_buf_empty → assert o_rd_key_code, then by code:
  - code == BREAK_CODE: set skip_next, drop_cnt++, stay IDLE.
  - code == EXT_CODE: drop_cnt++, stay IDLE, skip_next unchanged.
  - skip_next set: clear skip_next, drop_cnt++, stay IDLE.
  - otherwise: latch code into o_xlat_code, go XLAT.
- XLAT: register i_ascii_code into char register.
  - If 8'h00: drop_cnt++, go IDLE.
  - Else go SEND.
- SEND: while i_tx_full, hold, with o_wr_uart low. When !i_tx_full: o_wr_uart=1 and o_wr_data=char for one cycle; go SEND_LF if char==8'h0D and KB_CRLF_EN is defined, else IDLE.
- SEND_LF: same full-flag wait; write 8'h0A, then go IDLE.
- No pop occurs outside IDLE; the buffer absorbs keys while the UART is stalled.
- drop_cnt saturates at all-ones; it does not wrap.
- skip_next persists across SEND stalls and is cleared only by consuming a code or by reset.

## Timing
- Reset values: o_rd_key_code=0, o_wr_uart=0, o_wr_data=8'h00, o_xlat_code=8'h00, o_busy=0, o_drop_cnt=0, skip_next=0, state=IDLE.
- o_rd_key_code is combinational from state IDLE and !i_kb_buf_empty; i_key_code is sampled on the same edge.
- Best-case latency, pop to o_wr_uart: 2 cycles (pop in cycle N, XLAT in N+1, write in N+2).
- Throughput: one character per 3 cycles; back-to-back prefix/break codes are consumed at one per cycle.
- The o_wr_uart cycle always has i_tx_full=0 in that same cycle; the block never writes into a full FIFO.
- Reset asserted mid-SEND or mid-SEND_LF aborts the pending character. Nothing is written in the reset cycle, and IDLE is entered next cycle.
- i_tx_full rising in the cycle the block enters SEND: no write occurs until it falls.

## Configuration
- KB_CRLF_EN defined: an ASCII 8'h0D from the translator (Enter) is followed by 8'h0A in SEND_LF, so terminals get CR LF.
- KB_CRLF_EN undefined: SEND_LF state and logic are absent; Enter emits 8'h0D only.

## Test plan
- Bench translator model: 8'h1C→8'h61, 8'h5A→8'h0D, others→8'h00.
- Make/break: buffer holds 1C, F0, 1C → exactly one write of 8'h61, three pops, o_drop_cnt=2, skip_next=0 at end.
- Extended: buffer holds E0, 1C, E0, F0, 1C → one write 8'h61, o_drop_cnt=4.
- Backpressure: i_tx_full=1 for 20 cycles while 1C pending → o_wr_uart stays 0, no further pops. Full drops → single write 8'h61 next cycle, then pops resume.
- Enter: code 5A with KB_CRLF_EN → writes 8'h0D then 8'h0A. Without the macro → only 8'h0D.
- Unmapped/saturation/reset: 300 codes of 8'h77 → no writes, o_drop_cnt=8'hFF. Reset asserted during SEND of 8'h61 with i_tx_full=1 → no write, all outputs at reset values next cycle.
